// File: rtl/sync_generator_if.sv
// Control and status bundle of sync_generator: start/stop requests in, SYNC0 pulse train and timestamp out.
// DRIFT exists only when SYNC_GEN_DRIFT_EN is defined.
interface sync_generator_if;
  logic        START;
  logic [63:0] START_TIME;
  logic        STOP;
  logic        ECAT_SYNC;
  logic [63:0] ECAT_SYNC_TIME;
  logic        SET;
  logic        BUSY;
  logic [31:0] PULSE_CNT;
`ifdef SYNC_GEN_DRIFT_EN
  logic signed [15:0] DRIFT;
`endif

  modport master (
`ifdef SYNC_GEN_DRIFT_EN
    output DRIFT,
`endif
    output START, START_TIME, STOP,
    input  ECAT_SYNC, ECAT_SYNC_TIME, SET, BUSY, PULSE_CNT
  );

  modport slave (
`ifdef SYNC_GEN_DRIFT_EN
    input  DRIFT,
`endif
    input  START, START_TIME, STOP,
    output ECAT_SYNC, ECAT_SYNC_TIME, SET, BUSY, PULSE_CNT
  );
endinterface

// File: rtl/sync_generator.sv
// EtherCAT-DC-style SYNC0 pulse generator with a 64-bit ns timestamp advancing once per period.
// Optional SYNC_GEN_DRIFT_EN: per-period length = PERIOD_CNT + DRIFT, clamped to PULSE_WIDTH + 1.
module sync_generator #(
  parameter int unsigned     PERIOD_CNT  = 81920,
  parameter longint unsigned PERIOD_NS   = 500000,
  parameter int unsigned     PULSE_WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  sync_generator_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  localparam logic [17:0] PW_L   = 18'(PULSE_WIDTH);
  localparam logic [63:0] STEP_L = 64'(PERIOD_NS);

  state_e      state_q, state_d;
  logic [17:0] tick_q, tick_d;
  logic        stop_pending_q, stop_pending_d;
  logic        sync_q, sync_d;
  logic        set_q, set_d;
  logic        busy_q, busy_d;
  logic [31:0] pulse_cnt_q, pulse_cnt_d;
  logic [63:0] time_q, time_d;
  logic        load_period;
  logic [17:0] period_cur;
  logic        wrap;

`ifdef SYNC_GEN_DRIFT_EN
  logic [17:0] period_q, period_d;
  int          eff_period;

  // Drift is sampled whenever a new period begins; the clamp keeps at least one low tick per period.
  always_comb begin
    eff_period = int'(PERIOD_CNT) + int'(bus.DRIFT);
    if (eff_period < int'(PULSE_WIDTH) + 1) eff_period = int'(PULSE_WIDTH) + 1;
    period_d = load_period ? 18'(eff_period) : period_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) period_q <= '0;
    else     period_q <= period_d;
  end

  assign period_cur = period_q;
`else
  assign period_cur = 18'(PERIOD_CNT);
`endif

  assign wrap = (tick_q == period_cur - 18'd1);

  // NOTE: every variable gets its default first so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    tick_d         = tick_q;
    stop_pending_d = stop_pending_q;
    sync_d         = sync_q;
    set_d          = 1'b0;
    busy_d         = busy_q;
    pulse_cnt_d    = pulse_cnt_q;
    time_d         = time_q;
    load_period    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.START && !bus.STOP) begin
          state_d        = LOAD;
          set_d          = 1'b1;
          busy_d         = 1'b1;
          time_d         = bus.START_TIME;
          tick_d         = '0;
          pulse_cnt_d    = '0;
          stop_pending_d = 1'b0;
        end
      end
      LOAD: begin
        state_d     = RUN;
        tick_d      = '0;
        sync_d      = 1'b1;
        pulse_cnt_d = pulse_cnt_q + 32'd1;
        load_period = 1'b1;
      end
      RUN: begin
        if (wrap) begin
          // A STOP landing on the wrap cycle itself still prevents the next pulse.
          if (stop_pending_q || bus.STOP) begin
            state_d        = IDLE;
            busy_d         = 1'b0;
            sync_d         = 1'b0;
            tick_d         = '0;
            stop_pending_d = 1'b0;
          end else begin
            tick_d      = '0;
            sync_d      = 1'b1;
            pulse_cnt_d = pulse_cnt_q + 32'd1;
            time_d      = time_q + STEP_L;
            load_period = 1'b1;
          end
        end else begin
          tick_d         = tick_q + 18'd1;
          sync_d         = (tick_q + 18'd1) < PW_L;
          stop_pending_d = stop_pending_q | bus.STOP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= IDLE;
      tick_q         <= '0;
      stop_pending_q <= 1'b0;
      sync_q         <= 1'b0;
      set_q          <= 1'b0;
      busy_q         <= 1'b0;
      pulse_cnt_q    <= '0;
      time_q         <= '0;
    end else begin
      state_q        <= state_d;
      tick_q         <= tick_d;
      stop_pending_q <= stop_pending_d;
      sync_q         <= sync_d;
      set_q          <= set_d;
      busy_q         <= busy_d;
      pulse_cnt_q    <= pulse_cnt_d;
      time_q         <= time_d;
    end
  end

  assign bus.ECAT_SYNC      = sync_q;
  assign bus.SET            = set_q;
  assign bus.BUSY           = busy_q;
  assign bus.PULSE_CNT      = pulse_cnt_q;
  assign bus.ECAT_SYNC_TIME = time_q;

endmodule
